// File: rtl/poly_mult_coeff_pipe_pkg.sv
// Shared constants for the NTT-domain pointwise coefficient multiplier.
// Defaults target Q = 12289 with a 2^18 Montgomery radix.
`ifndef PMCP_LANE
`define PMCP_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

package poly_mult_coeff_pipe_pkg;
    localparam int Q_DEF    = 12289;
    localparam int RLOG_DEF = 18;
    localparam int QINV_DEF = 12287;
    localparam int R2_DEF   = 3186;
    localparam int N_DEF    = 1024;
endpackage

// File: rtl/mont_reduce_pipe.sv
// Two-stage Montgomery reduction: r = (x + ((x*QINV) mod R)*Q) / R,
// optionally folded into [0,Q) with one conditional subtract.
module mont_reduce_pipe #(
    parameter int COEFF_W     = 16,
    parameter int Q           = 12289,
    parameter int RLOG        = 18,
    parameter int QINV        = 12287,
    parameter int FULL_REDUCE = 1,
    localparam int XW         = 2*COEFF_W+2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [XW-1:0]      x,
    output logic [COEFF_W-1:0] r
);

    localparam logic [RLOG-1:0]    QINV_L = RLOG'(QINV);
    localparam logic [XW-1:0]      QX     = XW'(Q);
    localparam logic [COEFF_W-1:0] QC     = COEFF_W'(Q);

    logic [RLOG-1:0]    t_c;
    logic [RLOG-1:0]    t_q;
    logic [XW-1:0]      x_q;
    logic [XW-1:0]      s;
    logic [COEFF_W-1:0] r_raw;
    logic [COEFF_W-1:0] r_c;
    logic               unused_lo;

    assign t_c = x[RLOG-1:0] * QINV_L;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
            x_q <= '0;
        end else if (en) begin
            t_q <= t_c;
            x_q <= x;
        end
    end

    // Low RLOG bits of s are zero by construction of t.
    assign s         = x_q + ({{(XW-RLOG){1'b0}}, t_q} * QX);
    assign r_raw     = s[RLOG +: COEFF_W];
    assign unused_lo = ^s[RLOG-1:0];
    assign r_c       = ((FULL_REDUCE != 0) && (r_raw >= QC)) ? r_raw - QC : r_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (en) begin
            r <= r_c;
        end
    end

endmodule

// File: rtl/poly_mult_coeff_pipe.sv
// Pipelined LANES-wide pointwise multiplier mod Q with Montgomery reduction,
// valid/ready flow control and a per-polynomial coefficient index.
module poly_mult_coeff_pipe
    import poly_mult_coeff_pipe_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int COEFF_W     = 16,
    parameter int Q           = Q_DEF,
    parameter int RLOG        = RLOG_DEF,
    parameter int QINV        = QINV_DEF,
    parameter int R2          = R2_DEF,
    parameter int N           = N_DEF,
    parameter int FULL_REDUCE = 1,
    localparam int LW         = LANES*COEFF_W,
    localparam int IW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [LW-1:0] doa,
    input  logic [LW-1:0] dob,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] dout,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    localparam int XW                = 2*COEFF_W+2;
    localparam logic [XW-1:0] R2X    = XW'(R2);
    localparam logic [IW-1:0] LAST_I = IW'(N - LANES);
    localparam logic [IW-1:0] STEP_I = IW'(LANES);

    logic          adv;
    logic [5:0]    vld;
    logic [5:0]    mode_q;
    logic [LW-1:0] a_s1, a_s2, a_s3;
    logic [LW-1:0] t_s4, t_s5, t_s6;
    logic [LW-1:0] t3_bus;
    logic [LW-1:0] r6_bus;
    logic [IW-1:0] idx_q;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign adv       = !vld[5] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            mode_q <= '0;
            a_s1   <= '0;
            a_s2   <= '0;
            a_s3   <= '0;
            t_s4   <= '0;
            t_s5   <= '0;
            t_s6   <= '0;
        end else if (adv) begin
            vld    <= {vld[4:0], in_valid};
            mode_q <= {mode_q[4:0], mode};
            a_s1   <= doa;
            a_s2   <= a_s1;
            a_s3   <= a_s2;
            t_s4   <= t3_bus;
            t_s5   <= t_s4;
            t_s6   <= t_s5;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XW-1:0] a_x;
        logic [XW-1:0] b_x;
        logic [XW-1:0] p1_c;
        logic [XW-1:0] p1_q;
        logic [XW-1:0] p2_q;

        assign a_x  = XW'(`PMCP_LANE(doa, i, COEFF_W));
        assign b_x  = XW'(`PMCP_LANE(dob, i, COEFF_W));
        // mode 1 lifts b into Montgomery form via R^2 before the real product.
        assign p1_c = mode ? (R2X * b_x) : (a_x * b_x);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p1_q <= '0;
                p2_q <= '0;
            end else if (adv) begin
                p1_q <= p1_c;
                p2_q <= XW'(`PMCP_LANE(a_s3, i, COEFF_W))
                      * XW'(`PMCP_LANE(t3_bus, i, COEFF_W));
            end
        end

        mont_reduce_pipe #(
            .COEFF_W     (COEFF_W),
            .Q           (Q),
            .RLOG        (RLOG),
            .QINV        (QINV),
            .FULL_REDUCE (FULL_REDUCE)
        ) u_mont1 (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .x     (p1_q),
            .r     (`PMCP_LANE(t3_bus, i, COEFF_W))
        );

        mont_reduce_pipe #(
            .COEFF_W     (COEFF_W),
            .Q           (Q),
            .RLOG        (RLOG),
            .QINV        (QINV),
            .FULL_REDUCE (FULL_REDUCE)
        ) u_mont2 (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .x     (p2_q),
            .r     (`PMCP_LANE(r6_bus, i, COEFF_W))
        );
    end

    assign dout = mode_q[5] ? r6_bus : t_s6;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (out_valid && out_ready) begin
            idx_q <= (idx_q == LAST_I) ? '0 : idx_q + STEP_I;
        end
    end

    assign out_idx  = idx_q;
    assign out_last = (idx_q == LAST_I);

endmodule

// File: tb/tb_poly_mult_coeff_pipe.sv
// Directed and model-checked stimulus for the pointwise coefficient multiplier.
// Two lanes and a short polynomial keep index wrap frequent.
module tb_poly_mult_coeff_pipe;

    localparam int LANES = 2;
    localparam int CW    = 16;
    localparam int LW    = LANES*CW;
    localparam int N     = 16;
    localparam int IW    = 4;
    localparam int Q     = 12289;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [LW-1:0] doa = '0;
    logic [LW-1:0] dob = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] dout;
    logic [IW-1:0] out_idx;
    logic          out_last;

    int            tests = 0;
    int            fails = 0;
    logic [LW-1:0] exp_q[$];
    int            acc_q[$];
    logic [LW-1:0] exp_cur;
    int            cyc = 0;
    int            exp_idx = 0;
    bit            accepted = 0;
    bit            prev_stall = 0;
    bit            chk_lat = 1;
    bit            rand_ready = 0;
    logic [LW-1:0] prev_dout;
    logic [IW-1:0] prev_idx;
    longint        rinv = 0;

    poly_mult_coeff_pipe #(
        .LANES (LANES),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .doa       (doa),
        .dob       (dob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] ref_mul(input int unsigned a, input int unsigned b,
                                              input bit m);
        longint x;
        x = (longint'(a) * longint'(b)) % Q;
        if (!m) x = (x * rinv) % Q;
        return CW'(x);
    endfunction

    task automatic cycle();
        logic [LW-1:0] e;
        int            a;
        #1;
        chk("in_ready", in_ready, (!out_valid || out_ready));
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_dout", dout, prev_dout);
            chk("hold_idx", out_idx, prev_idx);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("dout", dout, e);
                chk("out_idx", out_idx, exp_idx);
                chk("out_last", out_last, (exp_idx == N - LANES));
                if (chk_lat) chk("latency", cyc - a, 6);
                exp_idx = (exp_idx + LANES) % N;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_dout  = dout;
        prev_idx   = out_idx;
        accepted   = in_valid && in_ready;
        if (accepted) begin
            exp_q.push_back(exp_cur);
            acc_q.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input bit m, input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic [LW-1:0] e);
        in_valid = 1'b1;
        mode     = m;
        doa      = a;
        dob      = b;
        exp_cur  = e;
        accepted = 0;
        for (int k = 0; k < 64; k++) begin
            out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("send_timeout", accepted, 1);
    endtask

    task automatic send_rand(input bit m);
        logic [CW-1:0] a0, a1, b0, b1;
        a0 = CW'($urandom_range(0, Q-1));
        a1 = CW'($urandom_range(0, Q-1));
        b0 = CW'($urandom_range(0, Q-1));
        b1 = CW'($urandom_range(0, Q-1));
        send(m, {a1, a0}, {b1, b0}, {ref_mul(a1, b1, m), ref_mul(a0, b0, m)});
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            cycle();
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        longint rmod;
        rmod = (longint'(1) << 18) % Q;
        for (longint i = 1; i < Q; i++) begin
            if ((rmod * i) % Q == 1) rinv = i;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed vectors: lane1 in the upper half
        send(1'b1, {16'd12288, 16'd2},    {16'd12288, 16'd3},    {16'd1,    16'd6});
        send(1'b1, {16'd100,   16'd0},    {16'd200,   16'd5},    {16'd7711, 16'd0});
        send(1'b0, {16'd4075,  16'd4075}, {16'd4075,  16'd1},    {16'd4075, 16'd1});
        send(1'b0, {16'd0,     16'd4075}, {16'd7,     16'd8150}, {16'd0,    16'd8150});
        drain();

        // Mode alternates every beat, back to back
        for (int k = 0; k < 16; k++) send_rand(1'(k % 2));
        drain();

        // Asynchronous reset with beats in flight
        for (int k = 0; k < 3; k++) send_rand(1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_idx", out_idx, 0);
        chk("midrst_last", out_last, 0);
        exp_q.delete();
        acc_q.delete();
        exp_idx    = 0;
        prev_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, {16'd3, 16'd2}, {16'd5, 16'd3}, {16'd15, 16'd6});
        drain();

        // Random backpressure
        rand_ready = 1;
        chk_lat    = 0;
        for (int k = 0; k < 20; k++) send_rand(1'($urandom % 2));
        drain();

        // Bulk random, both modes, full throughput
        rand_ready = 0;
        chk_lat    = 1;
        for (int k = 0; k < 3000; k++) send_rand(1'($urandom % 2));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
